// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: loader states, memory sizing and write-address width.
`timescale 1ns/1ps
package boot_loader_pkg;
    localparam int MEM_BYTES = 4096;
    localparam int MAX_WORDS = MEM_BYTES / 4;
    localparam int ADDR_W    = 12;

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;
endpackage

// File: rtl/boot_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_done pulses the cycle after the 4th byte.
`timescale 1ns/1ps
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  data,
    output logic        last,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0] idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= 2'd0;
            word      <= 32'd0;
            word_done <= 1'b0;
        end else begin
            word_done <= load && (idx == 2'd3);
            if (load) begin
                // Shift in from the top so the first byte lands in [7:0] after four loads.
                word <= {data, word[31:8]};
                idx  <= idx + 2'd1;
            end
        end
    end

    assign last = (idx == 2'd3);
endmodule

// File: rtl/boot_loader.sv
// Receives a length-prefixed, XOR-checked image byte stream and writes it word by word into memory,
// then releases the core reset once the checksum matches.
`timescale 1ns/1ps
module boot_loader #(
    parameter int MEM_BYTES = boot_loader_pkg::MEM_BYTES,
    parameter int MAX_WORDS = MEM_BYTES / 4
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              In_Valid,
    input  logic [7:0]                        In_Data,
    output logic                              In_Ready,
    output logic                              Mem_We,
    output logic [boot_loader_pkg::ADDR_W-1:0] Mem_Addr,
    output logic [31:0]                       Mem_Wdata,
    output logic                              Core_Reset,
    output logic                              Done,
    output logic                              Error
);
    import boot_loader_pkg::*;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t            state;
    logic [7:0]        len_lo;
    logic [7:0]        csum;
    logic [15:0]       nwords;
    logic [15:0]       wcnt;
    logic [ADDR_W-1:0] addr_q;
    logic              xfer;
    logic              load;
    logic              last;
    logic [31:0]       word;
    logic              word_done;
    logic [15:0]       len_n;

    assign xfer  = In_Valid && In_Ready;
    assign load  = xfer && (state == ST_DATA);
    assign len_n = {In_Data, len_lo};

    byte_packer u_packer (
        .clk       (Clk),
        .reset     (Reset),
        .load      (load),
        .data      (In_Data),
        .last      (last),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_LEN_LO;
            len_lo <= 8'd0;
            csum   <= 8'd0;
            nwords <= 16'd0;
            wcnt   <= 16'd0;
            addr_q <= '0;
        end else if (xfer) begin
            case (state)
                ST_LEN_LO: begin
                    len_lo <= In_Data;
                    csum   <= csum ^ In_Data;
                    state  <= ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    nwords <= len_n;
                    csum   <= csum ^ In_Data;
                    if (len_n == 16'd0)
                        state <= ST_CHK;
                    else if ({1'b0, len_n} > MAX_N)
                        state <= ST_ERR;
                    else
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    csum <= csum ^ In_Data;
                    if (last) begin
                        // Latch the address alongside the word the packer presents next cycle.
                        addr_q <= ADDR_W'({wcnt, 2'b00});
                        wcnt   <= wcnt + 16'd1;
                        if (wcnt == nwords - 16'd1)
                            state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    state <= (In_Data == csum) ? ST_DONE : ST_ERR;
                end
                default: state <= state;
            endcase
        end
    end

    assign In_Ready   = !Reset && (state == ST_LEN_LO || state == ST_LEN_HI ||
                                   state == ST_DATA   || state == ST_CHK);
    assign Mem_We     = word_done && !Reset;
    assign Mem_Addr   = Reset ? '0 : addr_q;
    assign Mem_Wdata  = Reset ? 32'd0 : word;
    assign Done       = !Reset && (state == ST_DONE);
    assign Error      = !Reset && (state == ST_ERR);
    assign Core_Reset = Reset || (state != ST_DONE);
endmodule

// File: tb/tb_boot_loader.sv
// Scenario bench for boot_loader: expected memory writes are queued as stimulus is driven and checked on Mem_We.
`timescale 1ns/1ps
module tb_boot_loader;
    typedef logic [7:0] bq_t[$];

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        In_Valid = 1'b0;
    logic [7:0]  In_Data = 8'h00;
    logic        In_Ready;
    logic        Mem_We;
    logic [11:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic        Core_Reset;
    logic        Done;
    logic        Error;

    int n_tests = 0;
    int n_fail  = 0;
    logic [43:0] exp_q[$];

    boot_loader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .In_Valid   (In_Valid),
        .In_Data    (In_Data),
        .In_Ready   (In_Ready),
        .Mem_We     (Mem_We),
        .Mem_Addr   (Mem_Addr),
        .Mem_Wdata  (Mem_Wdata),
        .Core_Reset (Core_Reset),
        .Done       (Done),
        .Error      (Error)
    );

    always #5 Clk = ~Clk;

    // Write monitor: every Mem_We must match the oldest expected write.
    always @(negedge Clk) begin
        if (Mem_We === 1'b1) begin
            logic [43:0] e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", Mem_Addr, Mem_Wdata);
            end else begin
                e = exp_q.pop_front();
                if ({Mem_Addr, Mem_Wdata} !== e) begin
                    n_fail++;
                    $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                             Mem_Addr, Mem_Wdata, e[43:32], e[31:0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        In_Valid = 1'b1;
        In_Data  = b;
        @(negedge Clk);
        In_Valid = 1'b0;
        In_Data  = 8'($urandom);
        idle(gap);
    endtask

    task automatic send_stream(input bq_t s, input int gap);
        foreach (s[i]) send(s[i], gap);
    endtask

    function automatic logic [7:0] xor_of(input bq_t s);
        logic [7:0] x = 8'h00;
        foreach (s[i]) x ^= s[i];
        return x;
    endfunction

    task automatic apply_reset();
        Reset = 1'b1;
        idle(2);
        Reset = 1'b0;
    endtask

    task automatic expect_drain(input string name);
        idle(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_writes: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle(2);
        n_tests++;
        if ({In_Ready, Mem_We, Core_Reset, Done, Error} !== 5'b00100 || Mem_Addr !== 12'h0 || Mem_Wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy/we/crst/done/err=%b addr=%h data=%h, required 00100 000 00000000",
                     {In_Ready, Mem_We, Core_Reset, Done, Error}, Mem_Addr, Mem_Wdata);
        end
        Reset = 1'b0;
        #1;
        n_tests++;
        if (In_Ready !== 1'b1 || Core_Reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b crst=%b, required rdy=1 crst=1", In_Ready, Core_Reset);
        end
        idle(1);
    endtask

    task automatic test_single();
        apply_reset();
        exp_q.push_back({12'h000, 32'h12345678});
        send_stream('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 0);
        n_tests++;
        if (Mem_We !== 1'b1) begin
            n_fail++;
            $display("FAIL single_we_timing: got Mem_We=%b the cycle after 4th byte, required 1", Mem_We);
        end
        n_tests++;
        if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_early: got Done=%b before CHK, required 0", Done);
        end
        send(8'h09, 0);
        n_tests++;
        if (Done !== 1'b1 || Core_Reset !== 1'b0 || In_Ready !== 1'b0 || Error !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done=%b crst=%b rdy=%b err=%b, required 1 0 0 0",
                     Done, Core_Reset, In_Ready, Error);
        end
        expect_drain("single");
    endtask

    task automatic test_two(input int gap, input string name);
        bq_t s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        apply_reset();
        exp_q.push_back({12'h000, 32'h44332211});
        exp_q.push_back({12'h004, 32'hDDCCBBAA});
        send_stream(s, gap);
        send(xor_of(s), 0);
        n_tests++;
        if (Done !== 1'b1 || Core_Reset !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: got done=%b crst=%b, required 1 0", name, Done, Core_Reset);
        end
        expect_drain(name);
    endtask

    task automatic test_bad_chk();
        apply_reset();
        exp_q.push_back({12'h000, 32'h12345678});
        send_stream('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08}, 0);
        n_tests++;
        if (Error !== 1'b1 || Core_Reset !== 1'b1 || In_Ready !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_chk_err: got err=%b crst=%b rdy=%b done=%b, required 1 1 0 0",
                     Error, Core_Reset, In_Ready, Done);
        end
        send_stream('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 0);
        n_tests++;
        if (Error !== 1'b1 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_chk_sticky: got err=%b done=%b, required 1 0", Error, Done);
        end
        expect_drain("bad_chk");
    endtask

    task automatic test_len_limits();
        apply_reset();
        send_stream('{8'h01, 8'h04}, 0);
        n_tests++;
        if (Error !== 1'b1 || In_Ready !== 1'b0 || Core_Reset !== 1'b1) begin
            n_fail++;
            $display("FAIL len_overflow: got err=%b rdy=%b crst=%b, required 1 0 1", Error, In_Ready, Core_Reset);
        end
        send_stream('{8'h11, 8'h22, 8'h33, 8'h44, 8'h00}, 0);
        expect_drain("len_overflow");
        apply_reset();
        send_stream('{8'h00, 8'h04}, 0);
        n_tests++;
        if (Error !== 1'b0 || In_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL len_max_accept: got err=%b rdy=%b, required 0 1", Error, In_Ready);
        end
    endtask

    task automatic test_zero();
        apply_reset();
        send_stream('{8'h00, 8'h00, 8'h00}, 0);
        n_tests++;
        if (Done !== 1'b1 || Core_Reset !== 1'b0 || Error !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: got done=%b crst=%b err=%b, required 1 0 0", Done, Core_Reset, Error);
        end
        expect_drain("zero_len");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_stream('{8'h02, 8'h00, 8'h11, 8'h22}, 0);
        apply_reset();
        exp_q.push_back({12'h000, 32'h12345678});
        send_stream('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09}, 0);
        n_tests++;
        if (Done !== 1'b1 || Core_Reset !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_done: got done=%b crst=%b, required 1 0", Done, Core_Reset);
        end
        expect_drain("reset_mid");
        // Reset coinciding with the 4th byte must cancel that word's write.
        apply_reset();
        send_stream('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34}, 0);
        In_Valid = 1'b1;
        In_Data  = 8'h12;
        Reset    = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0;
        Reset    = 1'b0;
        #1;
        n_tests++;
        if (Mem_We !== 1'b0 || In_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pending_we: got we=%b rdy=%b, required 0 1", Mem_We, In_Ready);
        end
        expect_drain("reset_pending");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two(0, "two_words");
        test_two(1, "gapped");
        test_bad_chk();
        test_len_limits();
        test_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning target memory size in bytes.
REQ-002 SHALL have parameter MAX_WORDS, default MEM_BYTES/4 = 1024, meaning largest loadable image in 32-bit words.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port In_Valid  input  1  byte on In_Data is offered.
REQ-006 SHALL have port In_Data  input  8  image byte stream.
REQ-007 SHALL have port In_Ready  output  1  loader accepts a byte this cycle; a transfer occurs when In_Valid and In_Ready are both high.
REQ-008 SHALL have port Mem_We  output  1  one-cycle word-write strobe to the pipeline memory.
REQ-009 SHALL have port Mem_Addr  output  12  byte address of the written word; bits [1:0] always 0.
REQ-010 SHALL have port Mem_Wdata  output  32  written word, little-endian: first byte received in [7:0].
REQ-011 SHALL have port Core_Reset  output  1  drives the pipeline Reset; high until a good image is loaded.
REQ-012 SHALL have port Done  output  1  image loaded and checksum matched.
REQ-013 SHALL have port Error  output  1  image rejected.

Function
REQ-014 Stream format SHALL be: LEN_LO, LEN_HI (word count N, 16-bit little-endian), then 4*N data bytes, then one CHK byte.
REQ-015 States SHALL be LEN_LO, LEN_HI, DATA, CHK, DONE, ERR; LEN_LO is entered after reset.
REQ-016 In_Ready SHALL be high in LEN_LO, LEN_HI, DATA and CHK, and low in DONE and ERR; bytes offered in DONE/ERR are ignored.
REQ-017 LEN_LO -> LEN_HI on a transfer; LEN_HI -> DATA on a transfer when 1 <= N <= MAX_WORDS, -> CHK when N = 0, -> ERR when N > MAX_WORDS.
REQ-018 In DATA, bytes SHALL be packed four at a time; Mem_We SHALL pulse high exactly one cycle, in the cycle after the 4th byte of a word transfers, with Mem_Addr and Mem_Wdata valid in that same cycle.
REQ-019 Word k (0-based) SHALL be written to Mem_Addr = 4*k; the word counter SHALL never wrap, because N <= MAX_WORDS is enforced.
REQ-020 DATA -> CHK on the transfer of byte 4*N.
REQ-021 A running XOR SHALL cover LEN_LO, LEN_HI and all data bytes.
REQ-022 In CHK, a transfer SHALL compare In_Data to the running XOR: on a match go to DONE, otherwise go to ERR.
REQ-023 Core_Reset SHALL fall, and Done SHALL rise, in the cycle after the matching CHK byte transfers; both then hold until Reset.
REQ-024 In ERR: Error = 1, Core_Reset = 1, Done = 0; ERR is left only through Reset.
REQ-025 Gaps in In_Valid SHALL stall progress without affecting packing or the checksum.

Reset
REQ-026 While Reset = 1 the outputs SHALL be: In_Ready=0, Mem_We=0, Mem_Addr=0, Mem_Wdata=0, Core_Reset=1, Done=0, Error=0.
REQ-027 Reset SHALL return the state to LEN_LO and clear the byte, word and checksum counters.
REQ-028 Reset mid-image SHALL abandon the image; words already written SHALL NOT be erased.
REQ-029 Reset mid-image SHALL suppress any pending Mem_We.

Structure
REQ-030 A shared package SHALL hold the state enum, MEM_BYTES, MAX_WORDS and the address width (12).
REQ-031 Byte-to-word packing (byte index 0..3, 32-bit shift register, word-complete pulse) SHALL be one sub-module named byte_packer.
REQ-032 The FSM, word counter and checksum SHALL live in boot_loader.
REQ-033 Core_Reset SHALL connect directly to Pipeline Reset.

Verification
REQ-034 Bytes 01 00 78 56 34 12 then CHK = 01^00^78^56^34^12 = 0x09 -> one Mem_We with Addr=0x000, Wdata=0x12345678; Done=1 and Core_Reset=0 one cycle after the CHK byte.
REQ-035 N=2, data bytes 11 22 33 44 AA BB CC DD, correct CHK -> writes 0x44332211 @0x000 and 0xDDCCBBAA @0x004; Done=1.
REQ-036 Same stream as REQ-034 with CHK=0x08 -> Error=1, Core_Reset stays 1, In_Ready=0; a further byte causes no write.
REQ-037 LEN bytes 01 04 (N=1025) -> ERR immediately after LEN_HI, no Mem_We ever.
REQ-038 N=0 (00 00) followed by CHK 0x00 -> Done with no writes; In_Valid toggled 1/0 every cycle during REQ-035 -> identical writes.
REQ-039 Reset asserted after 2 data bytes of REQ-035, then the full REQ-034 stream -> only the REQ-034 write at 0x000 and Done=1.
